load_store_unit: RTL

//  MEM-stage load/store unit sitting directly upstream of the unified byte-addressed Memory.

---
 rtl/load_store_unit_pkg.sv | 40 ++++
 rtl/load_store_unit_if.sv | 30 +++
 rtl/load_store_unit_extend.sv | 26 ++
 rtl/load_store_unit.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/load_store_unit_pkg.sv
// ---------------------------------------------------------------------------
// load_store_unit_pkg
// Purpose : shared constants for the MEM-stage load/store unit: RV32I
//           load/store funct3 codes, the Memory AU_inst_sel encoding and the
//           LSU state encoding, plus a funct3 legality helper.
// Ports   : none (package)
// ---------------------------------------------------------------------------
package load_store_unit_pkg;

  // RV32I load funct3
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // RV32I store funct3
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // Memory access size select (AU_inst_sel)
  localparam logic [1:0] MEM_SEL_WORD = 2'b00;
  localparam logic [1:0] MEM_SEL_HALF = 2'b01;
  localparam logic [1:0] MEM_SEL_BYTE = 2'b10;

  // LSU FSM states
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SPLIT = 1'b1;

  // True when funct3 names an RV32I load/store of the given direction
  function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
    if (is_store)
      return (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
    else
      return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
             (f3 == F3_LBU) || (f3 == F3_LHU);
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// ---------------------------------------------------------------------------
// load_store_unit_if
// Purpose : pipeline-side request/response bundle of the load/store unit.
// Signals : req_valid/req_write/req_funct3/req_addr/req_wdata (pipeline->LSU),
//           stall/resp_valid/resp_rdata/access_err (LSU->pipeline).
// Modports: master = pipeline, slave = load_store_unit.
// ---------------------------------------------------------------------------
interface load_store_unit_if #(
  parameter int ADDR_W = 8
);
  logic              req_valid;
  logic              req_write;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              stall;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              access_err;

  modport master (
    output req_valid, req_write, req_funct3, req_addr, req_wdata,
    input  stall, resp_valid, resp_rdata, access_err
  );

  modport slave (
    input  req_valid, req_write, req_funct3, req_addr, req_wdata,
    output stall, resp_valid, resp_rdata, access_err
  );
endinterface

// File: rtl/load_store_unit_extend.sv
// ---------------------------------------------------------------------------
// load_store_unit_extend
// Purpose : combinational sign/zero extension of byte or halfword data.
// Ports   : data_in   - raw data, payload in the low bits
//           sel       - MEM_SEL_WORD / MEM_SEL_HALF / MEM_SEL_BYTE
//           is_signed - 1: sign-extend, 0: zero-extend
//           data_out  - extended 32-bit result (word passes through)
// ---------------------------------------------------------------------------
module load_store_unit_extend
  import load_store_unit_pkg::*;
(
  input  logic [31:0] data_in,
  input  logic [1:0]  sel,
  input  logic        is_signed,
  output logic [31:0] data_out
);

  always_comb begin
    case (sel)
      MEM_SEL_BYTE: data_out = {{24{is_signed & data_in[7]}}, data_in[7:0]};
      MEM_SEL_HALF: data_out = {{16{is_signed & data_in[15]}}, data_in[15:0]};
      default:      data_out = data_in;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
// Purpose : MEM-stage load/store unit in front of the byte-addressed Memory.
//           Aligned and byte accesses pass straight through in one cycle;
//           misaligned W/H accesses are split into byte accesses while the
//           pipeline is stalled, and load data is reassembled and extended.
// Ports   : sclk, rst       - clock, synchronous active-high reset
//           bus (slave)     - pipeline request/response bundle
//           split_count     - saturating count of split accesses started
//           mem_read/mem_write/mem_sel/mem_signed/mem_addr/mem_wdata
//                           - Memory controls
//           mem_rdata       - combinational Memory read data
// ---------------------------------------------------------------------------
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int ADDR_W   = 8,
  parameter int CNT_W    = 16,
  parameter int SPLIT_EN = 1
) (
  input  logic              sclk,
  input  logic              rst,
  load_store_unit_if.slave  bus,
  output logic [CNT_W-1:0]  split_count,
  output logic              mem_read,
  output logic              mem_write,
  output logic [1:0]        mem_sel,
  output logic              mem_signed,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  logic [0:0]  state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [31:0] buf_q, buf_d;
  logic        start_split;

  logic [1:0]  size_sel;
  logic        is_store, legal, misaligned, signed_ld;
  logic [1:0]  last_idx;
  logic [31:0] asm_data, ext_data;
  logic [7:0]  store_byte;

  // Request decode: access size, direction, legality and alignment
  always_comb begin
    case (bus.req_funct3[1:0])
      2'b00:   size_sel = MEM_SEL_BYTE;
      2'b01:   size_sel = MEM_SEL_HALF;
      default: size_sel = MEM_SEL_WORD;
    endcase
  end

  assign is_store   = bus.req_write;
  assign legal      = f3_legal(is_store, bus.req_funct3);
  assign signed_ld  = !is_store && !bus.req_funct3[2];
  assign misaligned = ((size_sel == MEM_SEL_WORD) && (bus.req_addr[1:0] != 2'b00)) ||
                      ((size_sel == MEM_SEL_HALF) && bus.req_addr[0]);
  assign last_idx   = (size_sel == MEM_SEL_WORD) ? 2'd3 : 2'd1;
  assign store_byte = bus.req_wdata[8*idx_q +: 8];

  // The final byte of a split load arrives combinationally, so the result is
  // built from the buffer with the current byte merged in rather than waiting
  // a cycle for the buffer to update.
  always_comb begin
    asm_data = buf_q;
    asm_data[8*idx_q +: 8] = mem_rdata[7:0];
  end

  load_store_unit_extend u_extend (
    .data_in   (asm_data),
    .sel       (size_sel),
    .is_signed (signed_ld),
    .data_out  (ext_data)
  );

  // FSM outputs and next-state; everything is forced quiet while in reset so
  // no strobe reaches Memory during the reset cycle.
  always_comb begin
    state_d         = state_q;
    idx_d           = idx_q;
    buf_d           = buf_q;
    start_split     = 1'b0;
    bus.stall       = 1'b0;
    bus.resp_valid  = 1'b0;
    bus.resp_rdata  = 32'h0;
    bus.access_err  = 1'b0;
    mem_read        = 1'b0;
    mem_write       = 1'b0;
    mem_sel         = size_sel;
    mem_signed      = 1'b0;
    mem_addr        = bus.req_addr;
    mem_wdata       = bus.req_wdata;
    if (!rst) begin
      case (state_q)
        ST_IDLE: begin
          if (bus.req_valid) begin
            if (!legal || (misaligned && SPLIT_EN == 0)) begin
              bus.resp_valid = 1'b1;
              bus.access_err = 1'b1;
            end else if (!misaligned) begin
              mem_read       = !is_store;
              mem_write      = is_store;
              mem_signed     = signed_ld;
              bus.resp_valid = 1'b1;
              bus.resp_rdata = is_store ? 32'h0 : mem_rdata;
            end else begin
              mem_read    = !is_store;
              mem_write   = is_store;
              mem_sel     = MEM_SEL_BYTE;
              mem_wdata   = {24'h0, bus.req_wdata[7:0]};
              bus.stall   = 1'b1;
              buf_d       = {24'h0, mem_rdata[7:0]};
              idx_d       = 2'd1;
              state_d     = ST_SPLIT;
              start_split = 1'b1;
            end
          end
        end
        ST_SPLIT: begin
          if (!bus.req_valid) begin
            // Request withdrawn: drop the split; bytes already stored remain
            state_d = ST_IDLE;
            idx_d   = 2'd0;
          end else begin
            mem_read  = !is_store;
            mem_write = is_store;
            mem_sel   = MEM_SEL_BYTE;
            mem_addr  = bus.req_addr + ADDR_W'(idx_q);
            mem_wdata = {24'h0, store_byte};
            buf_d     = asm_data;
            if (idx_q == last_idx) begin
              bus.resp_valid = 1'b1;
              bus.resp_rdata = is_store ? 32'h0 : ext_data;
              state_d        = ST_IDLE;
              idx_d          = 2'd0;
            end else begin
              bus.stall = 1'b1;
              idx_d     = idx_q + 2'd1;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State, byte index, assembly buffer and saturating split counter
  always_ff @(posedge sclk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= 2'd0;
      buf_q       <= 32'h0;
      split_count <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      buf_q   <= buf_d;
      if (start_split && (split_count != {CNT_W{1'b1}}))
        split_count <= split_count + 1'b1;
    end
  end

endmodule
